// File: rtl/sweep_pkg.sv
// Shared widths and FSM state encoding for the frequency-sweep sequencer.
package sweep_pkg;

  parameter int FWORD_W = 32;
  parameter int CNT_W   = 24;
  parameter int IDX_W   = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    DWELL    = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/sweep_ctrl_if.sv
// DDS parameter write port plus the measurement-path handshake driven by sweep_ctrl.
interface sweep_ctrl_if #(
  parameter int FWORD_W = sweep_pkg::FWORD_W,
  parameter int IDX_W   = sweep_pkg::IDX_W
);
  import sweep_pkg::*;

  logic [FWORD_W-1:0] phase_fword;
  logic               param_wen;
  logic               meas_gate;
  logic               meas_req;
  logic               meas_last;
  logic               meas_ack;
  logic [IDX_W-1:0]   point_idx;

  modport master (
    output phase_fword, param_wen, meas_gate, meas_req, meas_last, point_idx,
    input  meas_ack
  );

  modport slave (
    input  phase_fword, param_wen, meas_gate, meas_req, meas_last, point_idx,
    output meas_ack
  );

endinterface

// File: rtl/sweep_timer.sv
// Loadable down-counter shared by the settle and dwell phases; expired flags the final cycle.
module sweep_timer #(
  parameter int CNT_W = sweep_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             expired
);
  import sweep_pkg::*;

  // Loading N-1 gives a phase of exactly N cycles ending on the cycle value reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word through a programmed list,
// settling, gating a measurement and waiting for the downstream ack at each point.
module sweep_ctrl #(
  parameter int FWORD_W = sweep_pkg::FWORD_W,
  parameter int CNT_W   = sweep_pkg::CNT_W,
  parameter int IDX_W   = sweep_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FWORD_W-1:0] cfg_f_start,
  input  logic [FWORD_W-1:0] cfg_f_step,
  input  logic [IDX_W-1:0]   cfg_n_points,
  input  logic [CNT_W-1:0]   cfg_settle,
  input  logic [CNT_W-1:0]   cfg_dwell,
  sweep_ctrl_if.master       bus,
  output logic               busy,
  output logic               done
);
  import sweep_pkg::*;

  state_t             state;
  logic [FWORD_W-1:0] fword;
  logic [FWORD_W-1:0] step_r;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx_r;
  logic [CNT_W-1:0]   settle_r;
  logic [CNT_W-1:0]   dwell_m1_r;
  logic               last_r;

  logic               timer_load;
  logic [CNT_W-1:0]   timer_load_value;
  logic [CNT_W-1:0]   timer_value;
  logic               timer_expired;
  logic               start_ok;

  assign start_ok = start && !abort && (cfg_n_points != '0);

  sweep_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expired    (timer_expired)
  );

  // Arm the timer for the phase being entered next: settle from LOAD, dwell otherwise.
  always_comb begin
    timer_load       = 1'b0;
    timer_load_value = dwell_m1_r;
    case (state)
      LOAD: begin
        timer_load = 1'b1;
        if (settle_r != '0) timer_load_value = settle_r - CNT_W'(1);
      end
      SETTLE: timer_load = timer_expired;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fword      <= '0;
      step_r     <= '0;
      idx        <= '0;
      last_idx_r <= '0;
      settle_r   <= '0;
      dwell_m1_r <= '0;
      last_r     <= 1'b0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= LOAD;
            fword      <= cfg_f_start;
            step_r     <= cfg_f_step;
            idx        <= '0;
            last_idx_r <= cfg_n_points - IDX_W'(1);
            settle_r   <= cfg_settle;
            dwell_m1_r <= (cfg_dwell == '0) ? '0 : cfg_dwell - CNT_W'(1);
            last_r     <= (cfg_n_points == IDX_W'(1));
          end
        end
        LOAD:   state <= (settle_r != '0) ? SETTLE : DWELL;
        SETTLE: if (timer_expired) state <= DWELL;
        DWELL:  if (timer_expired) state <= WAIT_ACK;
        WAIT_ACK: begin
          if (bus.meas_ack) begin
            if (idx == last_idx_r) begin
              state <= DONE;
            end else begin
              state  <= LOAD;
              fword  <= fword + step_r;
              idx    <= idx + IDX_W'(1);
              last_r <= ((idx + IDX_W'(1)) == last_idx_r);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phase_fword = fword;
  assign bus.point_idx   = idx;
  assign bus.param_wen   = (state == LOAD);
  assign bus.meas_gate   = (state == DWELL);
  assign bus.meas_req    = (state == WAIT_ACK);
  assign bus.meas_last   = last_r && (state == DWELL || state == WAIT_ACK);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: a queue holds the tuning words each sweep should write,
// and a negedge monitor pops them on every param_wen and checks gate length and meas_last.
module tb_sweep_ctrl;
  import sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] cfg_f_start;
  logic [31:0] cfg_f_step;
  logic [11:0] cfg_n_points;
  logic [23:0] cfg_settle;
  logic [23:0] cfg_dwell;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          wen_seen = 0;
  int          exp_n = 0;
  int          exp_gate = 1;
  int          gate_run = 0;
  int          done_cnt = 0;
  int          saved_done;
  bit          ok;

  sweep_ctrl_if bus ();

  always #5 clk = ~clk;

  sweep_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_f_start  (cfg_f_start),
    .cfg_f_step   (cfg_f_step),
    .cfg_n_points (cfg_n_points),
    .cfg_settle   (cfg_settle),
    .cfg_dwell    (cfg_dwell),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Program a sweep, pulse start for one cycle and queue the words it must write.
  task automatic applyStimulus(input logic [31:0] fs, input logic [31:0] st, input int n,
                               input int settle, input int dwell);
    logic [31:0] w;
    @(posedge clk) #1;
    cfg_f_start  = fs;
    cfg_f_step   = st;
    cfg_n_points = 12'(n);
    cfg_settle   = 24'(settle);
    cfg_dwell    = 24'(dwell);
    start        = 1'b1;
    wen_seen     = 0;
    exp_n        = n;
    exp_gate     = (dwell == 0) ? 1 : dwell;
    w            = fs;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(w);
      w = w + st;
    end
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic waitReq(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.meas_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulseAck(input int delay);
    repeat (delay) @(posedge clk) #1;
    bus.meas_ack = 1'b1;
    @(posedge clk) #1;
    bus.meas_ack = 1'b0;
  endtask

  task automatic runSweep(input int n, input int delay);
    bit seen;
    for (int p = 0; p < n; p++) begin
      waitReq(seen);
      checkOutput("req_seen", 32'(seen), 32'd1);
      if (!seen) return;
      pulseAck(delay);
    end
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    checkOutput("req_after_ack", 32'(bus.meas_req), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_falls", 32'(busy), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every DDS write must match the next queued word and index.
  always @(negedge clk) begin
    if (rst) begin
      gate_run = 0;
    end else begin
      if (bus.param_wen) begin
        checkOutput("wen_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          checkOutput("fword", bus.phase_fword, exp_q.pop_front());
          checkOutput("wen_idx", 32'(bus.point_idx), 32'(wen_seen));
        end
        wen_seen++;
      end
      if (bus.meas_gate || bus.meas_req)
        checkOutput("meas_last", 32'(bus.meas_last), 32'(wen_seen == exp_n));
      if (bus.meas_gate) begin
        gate_run++;
      end else begin
        if (gate_run > 0 && bus.meas_req) checkOutput("gate_len", 32'(gate_run), 32'(exp_gate));
        gate_run = 0;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    bus.meas_ack = 1'b0;
    cfg_f_start  = '0;
    cfg_f_step   = '0;
    cfg_n_points = '0;
    cfg_settle   = '0;
    cfg_dwell    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_fword", bus.phase_fword, 32'd0);
    checkOutput("rst_wen", 32'(bus.param_wen), 32'd0);
    checkOutput("rst_gate", 32'(bus.meas_gate), 32'd0);
    checkOutput("rst_req", 32'(bus.meas_req), 32'd0);
    checkOutput("rst_last", 32'(bus.meas_last), 32'd0);
    checkOutput("rst_idx", 32'(bus.point_idx), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    $display("[TB] basic sweep");
    applyStimulus(32'h1000_0000, 32'h0100_0000, 3, 4, 8);
    runSweep(3, 2);
    checkOutput("basic_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] zero settle and dwell");
    applyStimulus(32'hA5A5_0000, 32'h0000_0001, 1, 0, 0);
    @(negedge clk);
    checkOutput("zero_load_t1", 32'(bus.param_wen), 32'd1);
    @(negedge clk);
    checkOutput("zero_gate_t2", 32'(bus.meas_gate), 32'd1);
    @(negedge clk);
    checkOutput("zero_req_t3", 32'(bus.meas_req), 32'd1);
    checkOutput("zero_gate_off_t3", 32'(bus.meas_gate), 32'd0);
    bus.meas_ack = 1'b1;
    @(posedge clk) #1;
    bus.meas_ack = 1'b0;
    @(negedge clk);
    checkOutput("zero_done_t4", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("zero_idle", 32'(busy), 32'd0);

    $display("[TB] wrap-around");
    applyStimulus(32'hFFFF_FFF0, 32'h0000_0020, 2, 1, 2);
    runSweep(2, 0);

    $display("[TB] abort in dwell");
    saved_done = done_cnt;
    applyStimulus(32'h0000_4000, 32'h0000_0100, 4, 2, 5);
    waitReq(ok);
    checkOutput("abort_req0", 32'(ok), 32'd1);
    pulseAck(1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.meas_gate && (wen_seen == 2);
    end
    checkOutput("abort_gate_seen", 32'(ok), 32'd1);
    abort = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_gate", 32'(bus.meas_gate), 32'd0);
    checkOutput("abort_hold_fword", bus.phase_fword, 32'h0000_4100);
    exp_q.delete();
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_cnt), 32'(saved_done));
    applyStimulus(32'h0000_7000, 32'h0000_0010, 1, 0, 1);
    @(negedge clk);
    checkOutput("restart_idx", 32'(bus.point_idx), 32'd0);
    runSweep(1, 0);

    $display("[TB] ignored inputs");
    saved_done = done_cnt;
    applyStimulus(32'h0000_1234, 32'h1, 0, 0, 0);
    @(negedge clk);
    checkOutput("n0_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("n0_still_idle", 32'(busy), 32'd0);
    @(posedge clk) #1;
    cfg_n_points = 12'd2;
    start        = 1'b1;
    abort        = 1'b1;
    @(posedge clk) #1;
    start        = 1'b0;
    abort        = 1'b0;
    @(negedge clk);
    checkOutput("start_abort_drop", 32'(busy), 32'd0);
    applyStimulus(32'h0000_0100, 32'h0000_0010, 2, 6, 3);
    cfg_f_step   = 32'h0000_0999;
    cfg_f_start  = 32'h0;
    cfg_n_points = 12'd1;
    start        = 1'b1;
    @(posedge clk) #1;
    start        = 1'b0;
    bus.meas_ack = 1'b1;
    @(posedge clk) #1;
    bus.meas_ack = 1'b0;
    @(negedge clk);
    checkOutput("settle_ack_ignored", 32'(bus.meas_req), 32'd0);
    checkOutput("settle_busy", 32'(busy), 32'd1);
    runSweep(2, 1);
    checkOutput("ignored_done_count", 32'(done_cnt), 32'(saved_done + 1));

    $display("[TB] reset mid-sweep");
    applyStimulus(32'h0000_5000, 32'h0000_0040, 3, 1, 1);
    waitReq(ok);
    pulseAck(0);
    waitReq(ok);
    checkOutput("rst_in_wait_ack", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("mid_rst_fword", bus.phase_fword, 32'd0);
    checkOutput("mid_rst_idx", 32'(bus.point_idx), 32'd0);
    checkOutput("mid_rst_req", 32'(bus.meas_req), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Frequency-sweep sequencer for the frequency response detector. It sits directly upstream of the DDS and drives its `phase_fword`/`param_wen` write port, stepping through a programmed list of tuning words. At each point it waits a settle time, opens a measurement gate for a dwell time, and then handshakes with the downstream measurement path before it advances to the next point.

## Interface
- `FWORD_W`, 32: tuning-word width; matches the DDS phase accumulator.
- `CNT_W`, 24: width of the settle and dwell counters.
- `IDX_W`, 12: width of the point count and point index.

Ports:
- `clk` in 1: single clock, same domain as the DDS parameter port.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that starts a sweep.
- `abort` in 1: stops the sweep, effective next cycle.
- `cfg_f_start` in FWORD_W: tuning word of the first point.
- `cfg_f_step` in FWORD_W: increment added per point, unsigned, modulo 2^FWORD_W.
- `cfg_n_points` in IDX_W: number of points; 0 is invalid.
- `cfg_settle` in CNT_W: settle cycles after each frequency write; 0 is allowed.
- `cfg_dwell` in CNT_W: measurement gate length in cycles; 0 is treated as 1.
- `meas_ack` in 1: downstream has consumed the point's result.
- `phase_fword` out FWORD_W: tuning word to the DDS.
- `param_wen` out 1: one-cycle write strobe to the DDS.
- `meas_gate` out 1: high during the dwell window.
- `meas_req` out 1: high while waiting for `meas_ack`.
- `meas_last` out 1: high with `meas_gate`/`meas_req` on the final point.
- `point_idx` out IDX_W: index of the current point, 0-based.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a sweep completes.

## Operation
- Reset value of every output is 0, and the state is IDLE.
- Configuration is latched only on an accepted `start`. Config changes during a sweep have no effect.

State machine:
- IDLE:
  - `start`=1 and `cfg_n_points`≠0 → LOAD. The first point loads `cfg_f_start` and sets idx=0.
  - `start` with `cfg_n_points`=0 is ignored.
- LOAD (1 cycle):
  - `param_wen`=1 and `phase_fword` is valid.
  - → SETTLE if settle>0, else → DWELL.
- SETTLE: lasts exactly `cfg_settle` cycles, then → DWELL.
- DWELL: `meas_gate`=1 for exactly max(`cfg_dwell`,1) cycles, then → WAIT_ACK.
- WAIT_ACK:
  - `meas_req`=1 until `meas_ack` is sampled high. An ack is accepted in the same cycle it is seen.
  - `meas_ack` outside WAIT_ACK is ignored.
  - On ack, if idx = n_points−1 → DONE.
  - Otherwise fword ← fword + step (wraps modulo 2^FWORD_W), idx ← idx+1, → LOAD.
- DONE (1 cycle): `done`=1, then → IDLE.

Other rules:
- `phase_fword` holds its last value in IDLE, DONE and after an abort. The DDS keeps its last frequency.
- `abort` in any non-IDLE state → IDLE on the next edge.
  - `meas_gate`, `meas_req`, `meas_last` and `busy` go to 0.
  - No `done` pulse is issued.
  - `abort` takes priority over a same-cycle `meas_ack` or counter expiry.
- `start` while busy is ignored. `start` and `abort` in the same IDLE cycle: `abort` wins and `start` is dropped.
- `rst` mid-sweep returns every output to 0, including `phase_fword`, on the next edge.

## Timing
- `start` sampled at edge t → LOAD in cycle t+1, with `param_wen`=1 and the new `phase_fword` in that cycle.
- First SETTLE cycle is t+2. The first DWELL cycle is t+2+`cfg_settle`.
- `meas_req` rises in the cycle after the last `meas_gate` cycle.
- Ack sampled at edge a → next LOAD in cycle a+1, or DONE in cycle a+1.
- Per-point period = 1 + settle + max(dwell,1) + ack wait (≥1) cycles.
- `point_idx` and `meas_last` change only on entry to LOAD.

## Structure
- Package `sweep_pkg` holds:
  - the state enum (IDLE, LOAD, SETTLE, DWELL, WAIT_ACK, DONE);
  - the default widths `FWORD_W`, `CNT_W` and `IDX_W`.
- Sub-module `sweep_timer`: a loadable CNT_W down-counter with `load`, `value` and `expired` signals, shared by SETTLE and DWELL.
- The top level holds the FSM, the fword/idx registers and the latched configuration.

## Test plan
- Basic sweep:
  - Stimulus: start=0x1000_0000, step=0x0100_0000, n=3, settle=4, dwell=8, ack 2 cycles after `meas_req`.
  - Response: 3 `param_wen` pulses with fwords 0x1000_0000, 0x1100_0000, 0x1200_0000.
  - Each `meas_gate` is exactly 8 cycles and `meas_last` is set only on idx 2.
  - `done` is one pulse and `busy` falls with it.
- Zero settle and zero dwell, n=1:
  - Response: LOAD → DWELL immediately, `meas_gate` 1 cycle, `meas_req`.
  - Immediate ack → `done` at cycle t+4.
- Wrap-around:
  - Stimulus: start=0xFFFF_FFF0, step=0x20, n=2.
  - Response: second fword = 0x0000_0010.
- Abort during DWELL on point 1 of 4:
  - Response: next cycle `busy`=0, `meas_gate`=0, no `done`.
  - `phase_fword` holds the point-1 word.
  - A new `start` begins again at idx 0.
- Illegal and ignored inputs:
  - start with n=0 → no response.
  - `start` pulsed mid-sweep → no effect.
  - `meas_ack` during SETTLE → ignored.
  - Config changed mid-sweep → steps still use the latched `cfg_f_step`.
- Reset mid-sweep:
  - `rst` asserted in WAIT_ACK → all outputs 0 and the state is IDLE on the next edge.
